visualizador_resultado: RTL and testbench

- Sits directly downstream of the 2×4 multiplier/ALU stage.
- Captures the 4-bit result and its Z/N/C/V flags on a load strobe and holds them in registers.
- Shows the held result on a time-multiplexed, two-digit, active-low 7-segment display, either as an unsigned or a signed decimal number.
- Drives four flag LEDs; the overflow LED blinks.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/bin_a_7seg.sv | 28 ++
 rtl/visualizador_resultado.sv | 154 +++++++++++++++
 tb/tb_visualizador_resultado.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU result display: segment patterns, digit codes,
// flag bit positions and default scan/blink dividers.
package alu_pkg;

    localparam int REFRESH_DIV_DEF = 50000;
    localparam int BLINK_DIV_DEF   = 250;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // active-low gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic {
        DIG_UNITS = 1'b0,
        DIG_LEFT  = 1'b1
    } dig_sel_t;

    // magnitude of a 4-bit two's complement value; -8 maps to 8
    function automatic logic [3:0] abs4(input logic [3:0] v);
        return v[3] ? (~v + 4'd1) : v;
    endfunction

endpackage

// File: rtl/bin_a_7seg.sv
// Digit code to active-low 7-segment pattern; codes 0-9 are decimal digits,
// CODE_DASH gives a minus sign and anything else is blank.
module bin_a_7seg
    import alu_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            4'd8:      seg = SEG_8;
            4'd9:      seg = SEG_9;
            CODE_DASH: seg = SEG_DASH;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/visualizador_resultado.sv
// Holds the ALU result/flags and shows them on a two-digit multiplexed
// 7-segment display plus four flag LEDs with a blinking overflow LED.
//
// digit select state | meaning
// DIG_UNITS          | units digit anode active (an_o = 10)
// DIG_LEFT           | left digit anode active (an_o = 01)
module visualizador_resultado
    import alu_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEF,
    parameter int BLINK_DIV   = BLINK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] y_i,
    input  logic       z_i,
    input  logic       n_i,
    input  logic       c_i,
    input  logic       v_i,
    input  logic       signed_mode_i,
    output logic [6:0] seg_o,
    output logic [1:0] an_o,
    output logic [3:0] led_o,
    output logic       valid_o
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [3:0]    y_q;
    logic [3:0]    flags_q;
    logic          valid_q;
    logic [RW-1:0] refresh_q;
    logic          tick;
    logic [BW-1:0] blink_q;
    logic          phase_q;
    dig_sel_t      sel_q;
    dig_sel_t      sel_d;

    logic [3:0]    mag;
    logic [3:0]    units_code;
    logic [3:0]    left_code;
    logic [3:0]    code;
    logic [6:0]    seg_d;
    logic [1:0]    an_d;
    logic [3:0]    led_d;

    // capture registers; load_i is level-sampled, no clear besides reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= 4'd0;
            flags_q <= 4'd0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            y_q     <= y_i;
            flags_q <= {v_i, c_i, n_i, z_i};
            valid_q <= 1'b1;
        end
    end

    assign tick = (refresh_q == REFRESH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
        end else if (tick) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= DIG_UNITS;
        end else begin
            sel_q <= sel_d;
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (tick) begin
            sel_d = (sel_q == DIG_UNITS) ? DIG_LEFT : DIG_UNITS;
        end
    end

    // an overflow capture restarts the blink half-period with the LED lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= '0;
            phase_q <= 1'b1;
        end else if (load_i && v_i) begin
            blink_q <= '0;
            phase_q <= 1'b1;
        end else if (tick) begin
            if (blink_q == BLINK_LAST) begin
                blink_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                blink_q <= blink_q + 1'b1;
            end
        end
    end

    always_comb begin
        mag        = abs4(y_q);
        units_code = y_q;
        left_code  = CODE_BLANK;
        if (signed_mode_i) begin
            units_code = mag;
            left_code  = y_q[3] ? CODE_DASH : CODE_BLANK;
        end else if (y_q >= 4'd10) begin
            units_code = y_q - 4'd10;
            left_code  = 4'd1;
        end
        if (!valid_q) begin
            code = CODE_DASH;
        end else if (sel_q == DIG_LEFT) begin
            code = left_code;
        end else begin
            code = units_code;
        end
    end

    bin_a_7seg u_bin_a_7seg (
        .code (code),
        .seg  (seg_d)
    );

    always_comb begin
        an_d  = (sel_q == DIG_LEFT) ? 2'b01 : 2'b10;
        led_d = {flags_q[FLAG_V] & phase_q, flags_q[FLAG_C],
                 flags_q[FLAG_N], flags_q[FLAG_Z]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o <= SEG_BLANK;
            an_o  <= 2'b11;
            led_o <= 4'd0;
        end else begin
            seg_o <= seg_d;
            an_o  <= an_d;
            led_o <= led_d;
        end
    end

    assign valid_o = valid_q;

endmodule

// File: tb/tb_visualizador_resultado.sv
// Bench for visualizador_resultado with a fast scan (REFRESH_DIV=4, BLINK_DIV=2).
module tb_visualizador_resultado;

    localparam int RD = 4;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_i = 1'b0;
    logic [3:0] y_i = 4'd0;
    logic       z_i = 1'b0, n_i = 1'b0, c_i = 1'b0, v_i = 1'b0;
    logic       signed_mode_i = 1'b0;
    logic [6:0] seg_o;
    logic [1:0] an_o;
    logic [3:0] led_o;
    logic       valid_o;

    int n_chk = 0;
    int n_pass = 0;

    visualizador_resultado #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (load_i),
        .y_i           (y_i),
        .z_i           (z_i),
        .n_i           (n_i),
        .c_i           (c_i),
        .v_i           (v_i),
        .signed_mode_i (signed_mode_i),
        .seg_o         (seg_o),
        .an_o          (an_o),
        .led_o         (led_o),
        .valid_o       (valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            10: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    // reference model: expected registered outputs pushed each edge
    logic [13:0] sb[$];
    logic [3:0]  m_y;
    logic        m_z, m_n, m_c, m_v, m_val, m_sel, m_ph, m_tick;
    int          m_cnt, m_bcnt, m_sy;
    logic [6:0]  e_seg;
    logic [1:0]  e_an;
    logic [3:0]  e_led;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_y = 4'd0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_val = 0;
            m_cnt = 0; m_sel = 0; m_bcnt = 0; m_ph = 1;
            sb.delete();
        end else begin
            m_sy = m_y[3] ? int'(m_y) - 16 : int'(m_y);
            if (!m_val) e_seg = enc(10);
            else if (signed_mode_i)
                e_seg = m_sel ? (m_sy < 0 ? enc(10) : enc(11)) : enc(m_sy < 0 ? -m_sy : m_sy);
            else
                e_seg = m_sel ? (m_y >= 10 ? enc(1) : enc(11)) : enc(int'(m_y) % 10);
            e_an  = m_sel ? 2'b01 : 2'b10;
            e_led = {m_v & m_ph, m_c, m_n, m_z};
            m_tick = (m_cnt == RD - 1);
            if (load_i && v_i) begin
                m_ph = 1; m_bcnt = 0;
            end else if (m_tick) begin
                if (m_bcnt == BD - 1) begin m_bcnt = 0; m_ph = !m_ph; end
                else m_bcnt++;
            end
            m_cnt = m_tick ? 0 : m_cnt + 1;
            if (m_tick) m_sel = !m_sel;
            if (load_i) begin
                m_y = y_i; m_z = z_i; m_n = n_i; m_c = c_i; m_v = v_i; m_val = 1;
            end
            sb.push_back({e_seg, e_an, e_led, m_val});
        end
    end

    always @(negedge clk) begin
        logic [13:0] e;
        if (!rst_n) begin
            check("rst_seg", seg_o, 7'b1111111);
            check("rst_an", an_o, 2'b11);
            check("rst_led", led_o, 4'd0);
            check("rst_valid", valid_o, 1'b0);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out", {seg_o, an_o, led_o, valid_o}, e);
        end
    end

    // drive a one-cycle capture, return once the outputs reflect it
    task automatic load_val(input logic [3:0] y, input logic z, n, c, v);
        load_i = 1; y_i = y; z_i = z; n_i = n; c_i = c; v_i = v;
        @(posedge clk); #2;
        load_i = 0;
        @(posedge clk); #2;
    endtask

    task automatic wait_an(input logic [1:0] want, input string tag);
        bit hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (an_o == want) hit = 1;
        end
        if (!hit) check(tag, an_o, want);
    endtask

    task automatic wait_led3(input logic want, input string tag);
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (led_o[3] == want) hit = 1;
        end
        if (!hit) check(tag, led_o[3], want);
    endtask

    int          run;
    logic [1:0]  an_before, an_swap, an_cur;
    logic [6:0]  seg_exp;
    bit          synced;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hold_an", an_o, 2'b11);
        @(posedge clk); #2;
        rst_n = 1;
        @(posedge clk); @(negedge clk);
        check("post_rst_an", an_o, 2'b10);
        check("post_rst_seg", seg_o, 7'b0111111);
        check("post_rst_valid", valid_o, 1'b0);

        // unsigned 12
        load_val(4'b1100, 0, 0, 0, 0);
        wait_an(2'b10, "to_units_u");
        check("uns_units", seg_o, 7'b0100100);
        check("uns_led", led_o, 4'b0000);
        check("uns_valid", valid_o, 1'b1);
        wait_an(2'b01, "to_left_u");
        check("uns_left", seg_o, 7'b1111001);

        // signed -4 then -8
        signed_mode_i = 1;
        load_val(4'b1100, 0, 1, 0, 0);
        wait_an(2'b01, "to_left_s");
        check("sgn_left", seg_o, 7'b0111111);
        wait_an(2'b10, "to_units_s");
        check("sgn_units", seg_o, 7'b0011001);
        check("sgn_led_n", led_o[1], 1'b1);
        load_val(4'b1000, 0, 1, 0, 0);
        wait_an(2'b10, "to_units_s8");
        check("sgn_units8", seg_o, 7'b0000000);

        // overflow blink
        signed_mode_i = 0;
        load_val(4'b0000, 0, 0, 1, 1);
        @(negedge clk);
        check("ovf_led_c", led_o[2], 1'b1);
        wait_led3(1'b0, "blink_low_wait");
        wait_led3(1'b1, "blink_high_wait");
        run = 0;
        while (led_o[3] && run < 40) begin run++; @(negedge clk); end
        check("blink_on_len", run, 8);
        run = 0;
        while (!led_o[3] && run < 40) begin run++; @(negedge clk); end
        check("blink_off_len", run, 8);
        check("blink_c_steady", led_o[2], 1'b1);
        wait_led3(1'b0, "blink_low_wait2");
        load_val(4'b0000, 0, 0, 1, 1);
        @(negedge clk);
        check("blink_restart", led_o[3], 1'b1);
        load_val(4'b0000, 0, 0, 1, 0);
        @(negedge clk);
        check("blink_clear", led_o[3], 1'b0);

        // capture exactly on a wrap cycle
        @(posedge clk); #2;
        synced = 0;
        for (int i = 0; i < 10 && !synced; i++) begin
            if (m_cnt == RD - 1) synced = 1;
            else begin @(posedge clk); #2; end
        end
        if (!synced) check("tick_sync", m_cnt, RD - 1);
        an_before = an_o;
        an_swap = {an_before[0], an_before[1]};
        seg_exp = (an_swap == 2'b10) ? 7'b1111000 : 7'b1111111;
        load_i = 1; y_i = 4'b0111; z_i = 0; n_i = 0; c_i = 0; v_i = 0;
        @(posedge clk); #2;
        load_i = 0;
        @(negedge clk);
        check("tick_an_hold", an_o, an_before);
        @(negedge clk);
        check("tick_an_switch", an_o, an_swap);
        check("tick_seg", seg_o, seg_exp);
        an_cur = an_o;
        run = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an_o != an_cur) break;
            run++;
        end
        check("anode_period", run, RD);

        // reset in the middle of a scan
        load_val(4'b0101, 1, 1, 0, 0);
        wait_an(2'b01, "to_left_rst");
        #2;
        rst_n = 0;
        #1;
        check("mid_rst_seg", seg_o, 7'b1111111);
        check("mid_rst_an", an_o, 2'b11);
        check("mid_rst_led", led_o, 4'd0);
        check("mid_rst_valid", valid_o, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
        @(posedge clk); @(negedge clk);
        check("restart_an", an_o, 2'b10);
        check("restart_seg", seg_o, 7'b0111111);
        check("restart_led", led_o, 4'd0);
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
